// File: rtl/abs_mag_stream.sv
// Streaming |x| stage with a 1-entry skid buffer, most-negative clamp and saturation counter.
// Optional peak tracking is enabled by defining ABS_MAG_PEAK_TRACK_EN.
module abs_mag_stream #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 32,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              iclk,
  input  logic              irstn,
  input  logic              ivalid,
  output logic              oready,
  input  logic [DATA_W-1:0] idata,
  input  logic [IDX_W-1:0]  iidx,
  output logic              ovalid,
  input  logic              iready,
  output logic [DATA_W-1:0] odata,
  output logic [IDX_W-1:0]  oidx,
  output logic              osat,
  input  logic              iclr,
  output logic [CNT_W-1:0]  osat_cnt
`ifdef ABS_MAG_PEAK_TRACK_EN
  ,
  output logic [DATA_W-1:0] opeak,
  output logic [IDX_W-1:0]  opeak_idx
`endif
);

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] mag;
  logic              sat_in;
  logic              in_xfer, out_xfer, out_free, skid_nxt;

  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic [IDX_W-1:0]  skid_idx;
  logic              skid_sat;

  always_comb begin
    sat_in   = (idata == MIN_NEG) && (SATURATE != 0);
    mag      = idata[DATA_W-1] ? (~idata + DATA_W'(1)) : idata;
    if (sat_in) mag = MAX_POS;
    in_xfer  = ivalid && oready;
    out_xfer = ovalid && iready;
    out_free = !ovalid || iready;
    // The skid holds a beat only while the output register cannot take it.
    skid_nxt = !out_free && (skid_full || in_xfer);
  end

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      ovalid    <= 1'b0;
      oready    <= 1'b1;
      odata     <= '0;
      oidx      <= '0;
      osat      <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_idx  <= '0;
      skid_sat  <= 1'b0;
    end else begin
      oready    <= !skid_nxt;
      skid_full <= skid_nxt;
      if (skid_full) begin
        // Skid beat is older than anything upstream, so it drains first.
        if (out_free) begin
          ovalid <= 1'b1;
          odata  <= skid_data;
          oidx   <= skid_idx;
          osat   <= skid_sat;
        end
      end else if (in_xfer) begin
        if (out_free) begin
          ovalid <= 1'b1;
          odata  <= mag;
          oidx   <= iidx;
          osat   <= sat_in;
        end else begin
          skid_data <= mag;
          skid_idx  <= iidx;
          skid_sat  <= sat_in;
        end
      end else if (out_xfer) begin
        ovalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (!irstn)
      osat_cnt <= '0;
    else if (iclr)
      osat_cnt <= '0;
    else if (in_xfer && sat_in && (osat_cnt != {CNT_W{1'b1}}))
      osat_cnt <= osat_cnt + CNT_W'(1);
  end

`ifdef ABS_MAG_PEAK_TRACK_EN
  always_ff @(posedge iclk) begin
    if (!irstn) begin
      opeak     <= '0;
      opeak_idx <= '0;
    end else if (iclr) begin
      // A beat leaving in the clear cycle seeds the new peak.
      opeak     <= out_xfer ? odata : '0;
      opeak_idx <= out_xfer ? oidx  : '0;
    end else if (out_xfer && (odata > opeak)) begin
      opeak     <= odata;
      opeak_idx <= oidx;
    end
  end
`endif

endmodule

// File: tb/tb_abs_mag_stream.sv
// Bench for abs_mag_stream: directed steps plus random traffic against a queue-based model.
module tb_abs_mag_stream;

  logic        iclk = 1'b0;
  logic        irstn = 1'b0;
  logic        ivalid = 1'b0, iready = 1'b0, iclr = 1'b0;
  logic [15:0] idata = '0;
  logic [31:0] iidx = '0;

  logic        oready, ovalid, osat;
  logic [15:0] odata;
  logic [31:0] oidx;
  logic [1:0]  osat_cnt;
  logic        n_oready, n_ovalid, n_osat;
  logic [15:0] n_odata;
  logic [31:0] n_oidx;
  logic [15:0] n_osat_cnt;
`ifdef ABS_MAG_PEAK_TRACK_EN
  logic [15:0] opeak, n_opeak;
  logic [31:0] opeak_idx, n_opeak_idx;
`endif

  always #5 iclk = ~iclk;

  abs_mag_stream #(.DATA_W(16), .IDX_W(32), .SATURATE(1), .CNT_W(2)) u_dut (
    .iclk(iclk), .irstn(irstn), .ivalid(ivalid), .oready(oready), .idata(idata), .iidx(iidx),
    .ovalid(ovalid), .iready(iready), .odata(odata), .oidx(oidx), .osat(osat),
    .iclr(iclr), .osat_cnt(osat_cnt)
`ifdef ABS_MAG_PEAK_TRACK_EN
    , .opeak(opeak), .opeak_idx(opeak_idx)
`endif
  );

  abs_mag_stream #(.DATA_W(16), .IDX_W(32), .SATURATE(0), .CNT_W(16)) u_ns (
    .iclk(iclk), .irstn(irstn), .ivalid(ivalid), .oready(n_oready), .idata(idata), .iidx(iidx),
    .ovalid(n_ovalid), .iready(iready), .odata(n_odata), .oidx(n_oidx), .osat(n_osat),
    .iclr(iclr), .osat_cnt(n_osat_cnt)
`ifdef ABS_MAG_PEAK_TRACK_EN
    , .opeak(n_opeak), .opeak_idx(n_opeak_idx)
`endif
  );

  typedef struct {
    logic [15:0] m1;   // clamped magnitude
    logic        s1;
    logic [15:0] m0;   // exact unsigned magnitude
    logic [31:0] idx;
  } exp_t;

  exp_t        q[$];
  int          cnt_m;
  logic [15:0] peak_m;
  logic [31:0] peak_idx_m;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] d, input logic [31:0] ix);
    exp_t e;
    int   sv, m;
    sv    = int'($signed(d));
    m     = (sv < 0) ? -sv : sv;
    e.s1  = (m == 32768);
    e.m1  = e.s1 ? 16'h7FFF : m[15:0];
    e.m0  = m[15:0];
    e.idx = ix;
    return e;
  endfunction

  // One clock: drive inputs, check state against the model, advance the model across the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic [31:0] ix,
                      input logic rdy, input logic clr);
    exp_t e;
    logic in_acc, out_acc;
    @(negedge iclk);
    ivalid = v; idata = d; iidx = ix; iready = rdy; iclr = clr;
    #1;
    check("ovalid", ovalid, q.size() > 0);
    check("oready", oready, q.size() < 2);
    check("ns_ovalid", n_ovalid, q.size() > 0);
    check("osat_cnt", osat_cnt, cnt_m);
    check("ns_osat_cnt", n_osat_cnt, 0);
`ifdef ABS_MAG_PEAK_TRACK_EN
    check("opeak", opeak, peak_m);
    check("opeak_idx", opeak_idx, peak_idx_m);
`endif
    out_acc = (q.size() > 0) && rdy;
    in_acc  = v && (q.size() < 2);
    if (q.size() > 0) begin
      e = q[0];
      check("odata", odata, e.m1);
      check("oidx", oidx, e.idx);
      check("osat", osat, e.s1);
      check("ns_odata", n_odata, e.m0);
      check("ns_osat", n_osat, 0);
    end
    if (out_acc) begin
      e = q.pop_front();
      if (clr || e.m1 > peak_m) begin peak_m = e.m1; peak_idx_m = e.idx; end
    end else if (clr) begin
      peak_m = '0; peak_idx_m = '0;
    end
    if (in_acc) begin
      e = model(d, ix);
      q.push_back(e);
      if (e.s1 && cnt_m < 3) cnt_m++;
    end
    if (clr) cnt_m = 0;
    @(posedge iclk);
  endtask

  task automatic do_reset();
    @(negedge iclk);
    irstn = 1'b0; ivalid = 1'b0; iready = 1'b0; iclr = 1'b0;
    @(posedge iclk);
    #1;
    q.delete(); cnt_m = 0; peak_m = '0; peak_idx_m = '0;
    check("rst_ovalid", ovalid, 0);
    check("rst_oready", oready, 1);
    check("rst_odata", odata, 0);
    check("rst_oidx", oidx, 0);
    check("rst_osat", osat, 0);
    check("rst_cnt", osat_cnt, 0);
    @(negedge iclk);
    irstn = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] vals [5];
    vals[0] = 16'd5; vals[1] = 16'hFFFB; vals[2] = 16'd0; vals[3] = 16'hFFFF; vals[4] = 16'h7FFF;
    cnt_m = 0; peak_m = '0; peak_idx_m = '0;
    do_reset();

    // Basic stream at full rate
    for (int i = 0; i < 5; i++) step(1'b1, vals[i], 32'(i), 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Most-negative input, both clamp modes
    step(1'b1, 16'h8000, 32'd100, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: 8 beats, ready pattern 1,0,0,1,...
    for (int i = 0; i < 8; i++) step(1'b1, 16'(16'hFFF0 + i), 32'(200 + i), (i % 4 == 0) || (i % 4 == 3), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, '0, '0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Counter hold at 3, then clear beats a coincident saturating transfer
    for (int i = 0; i < 4; i++) step(1'b1, 16'h8000, 32'(300 + i), 1'b1, 1'b0);
    step(1'b1, 16'h8000, 32'd304, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset with output and skid both occupied
    for (int i = 0; i < 3; i++) step(1'b1, 16'(i + 40), 32'(400 + i), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'(i + 60), 32'(500 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      step($urandom_range(0, 3) != 0, d, 32'(1000 + i), $urandom_range(0, 2) != 0,
           $urandom_range(0, 30) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef ABS_MAG_PEAK_TRACK_EN
    step(1'b0, '0, '0, 1'b1, 1'b1);
    step(1'b1, 16'hFFF9, 32'd10, 1'b1, 1'b0);
    step(1'b1, 16'd3,    32'd11, 1'b1, 1'b0);
    step(1'b1, 16'd7,    32'd12, 1'b1, 1'b0);
    step(1'b1, 16'hFFF7, 32'd13, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge iclk); #1;
    check("peak_dir", opeak, 9);
    check("peak_idx_dir", opeak_idx, 13);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    @(negedge iclk); #1;
    check("peak_clr", opeak, 0);
    check("peak_idx_clr", opeak_idx, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
